// File: rtl/ps2_kbd_rx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared types and constants for the PS/2 keyboard receiver:
//             frame FSM state enum, prefix scancodes, event layout.
//  Revision : 1.0  initial release
// ============================================================================
package ps2_pkg;

  // Frame deserialiser states
  typedef enum logic [1:0] {
    FRM_IDLE   = 2'd0,
    FRM_DATA   = 2'd1,
    FRM_PARITY = 2'd2,
    FRM_STOP   = 2'd3
  } frame_state_e;

  // Prefix scancodes
  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  // Event word layout: {brk, ext, code[7:0]}
  localparam int PS2_EVT_W        = 10;
  localparam int PS2_EVT_BRK_BIT  = 9;
  localparam int PS2_EVT_EXT_BIT  = 8;
  localparam int PS2_EVT_CODE_MSB = 7;
  localparam int PS2_EVT_CODE_LSB = 0;

  // True when data plus parity bit carry an odd number of ones
  function automatic logic ps2_odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_kbd_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ps2_kbd_rx_if
//  Purpose  : CPU read port of the PS/2 keyboard event FIFO.
//             master = receiver side (drives data), slave = CPU side.
//  Revision : 1.0  initial release
// ============================================================================
interface ps2_kbd_rx_if #(
  parameter int FIFO_DEPTH = 8
) ();

  logic                               rd_en;
  logic                               rd_valid;
  logic [ps2_pkg::PS2_EVT_W-1:0]      rd_data;
  logic [$clog2(FIFO_DEPTH):0]        fifo_count;

  modport master (
    input  rd_en,
    output rd_valid,
    output rd_data,
    output fifo_count
  );

  modport slave (
    output rd_en,
    input  rd_valid,
    input  rd_data,
    input  fifo_count
  );

endinterface
`default_nettype wire

// File: rtl/ps2_kbd_rx_event_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ps2_event_fifo
//  Purpose  : Synchronous first-word-fall-through FIFO. A push into a full
//             FIFO is accepted only when a pop happens in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               push_i,
  input  wire logic [WIDTH-1:0]   push_data_i,
  input  wire logic               pop_i,
  output logic      [WIDTH-1:0]   pop_data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  logic w_do_pop;
  logic w_do_push;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (w_do_push && !w_do_pop)      count_q <= count_q + 1'b1;
      else if (w_do_pop && !w_do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ps2_kbd_rx
//  Purpose  : PS/2 keyboard receiver: line synchronisers, clock de-glitch
//             filter, 11-bit frame deserialiser, E0/F0 prefix decoder and
//             CPU-readable event FIFO with sticky error flags.
//  Options  : PS2_KBD_EXT_DECODE_EN - enables E0/F0 decoding and key_held;
//             when undefined every good byte is queued raw, key_held = 0.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_kbd_rx #(
  parameter int         CLK_HZ         = 50_000_000,
  parameter int         FIFO_DEPTH     = 8,
  parameter int         FILTER_LEN     = 8,
  parameter int         TIMEOUT_CYCLES = 100_000,
  parameter logic [7:0] KEY_CODE       = 8'h29
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         ps2_clk,
  input  wire logic         ps2_dat,
  input  wire logic         err_clr,
  ps2_kbd_rx_if.master      rd_if,
  output logic              key_held,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overflow_err
);

  import ps2_pkg::*;

  localparam logic [1:0] S_IDLE   = FRM_IDLE;
  localparam logic [1:0] S_DATA   = FRM_DATA;
  localparam logic [1:0] S_PARITY = FRM_PARITY;
  localparam logic [1:0] S_STOP   = FRM_STOP;

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------------------------------------------------------- sync
  logic [1:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       w_clk_s;
  logic       w_dat_s;

  // Two-flop synchronisers; lines idle high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
    end
  end

  assign w_clk_s = clk_sync_q[1];
  assign w_dat_s = dat_sync_q[1];

  // -------------------------------------------------------------- filter
  logic [FCW-1:0] filt_cnt_q;
  logic           filt_q;
  logic           filt_prev_q;
  logic           w_fall;

  // Filtered clock flips only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_cnt_q  <= '0;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
    end else begin
      filt_prev_q <= filt_q;
      if (w_clk_s == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_q     <= w_clk_s;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

  assign w_fall = filt_prev_q & ~filt_q;

  // ----------------------------------------------------------- frame FSM
  logic [1:0]    state_q,   state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q,   shift_d;
  logic          par_q,     par_d;
  logic [TW-1:0] tmr_q,     tmr_d;
  logic          byte_vld_q, byte_vld_d;
  logic          perr_evt_q, perr_evt_d;
  logic          ferr_evt_q, ferr_evt_d;

  // Next-state: shift bits on filtered falling edges, watchdog between edges
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tmr_d      = tmr_q;
    byte_vld_d = 1'b0;
    perr_evt_d = 1'b0;
    ferr_evt_d = 1'b0;
    if (state_q != S_IDLE) tmr_d = tmr_q + 1'b1;
    if (w_fall) begin
      tmr_d = '0;
      case (state_q)
        S_IDLE: begin
          if (!w_dat_s) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d   = {w_dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = w_dat_s;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!ps2_odd_parity_ok(shift_q, par_q)) perr_evt_d = 1'b1;
          else if (!w_dat_s)                      ferr_evt_d = 1'b1;
          else                                    byte_vld_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end else if ((state_q != S_IDLE) && (tmr_q == TW'(TIMEOUT_CYCLES - 1))) begin
      state_d    = S_IDLE;
      ferr_evt_d = 1'b1;
      tmr_d      = '0;
    end
  end

  // Frame FSM registers; a completed byte stays in shift_q for the decoder
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmr_q      <= '0;
      byte_vld_q <= 1'b0;
      perr_evt_q <= 1'b0;
      ferr_evt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmr_q      <= tmr_d;
      byte_vld_q <= byte_vld_d;
      perr_evt_q <= perr_evt_d;
      ferr_evt_q <= ferr_evt_d;
    end
  end

  // ------------------------------------------------------------- decoder
  logic                 w_push;
  logic [PS2_EVT_W-1:0] w_evt;

`ifdef PS2_KBD_EXT_DECODE_EN
  logic ext_q, ext_d;
  logic brk_q, brk_d;
  logic key_held_q, key_held_d;

  // Prefix tracking; any non-prefix byte becomes an event and clears prefixes
  always_comb begin
    ext_d      = ext_q;
    brk_d      = brk_q;
    key_held_d = key_held_q;
    w_push     = 1'b0;
    w_evt      = {brk_q, ext_q, shift_q};
    if (perr_evt_q || ferr_evt_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_vld_q) begin
      if (shift_q == PS2_EXT_PREFIX) begin
        ext_d = 1'b1;
      end else if (shift_q == PS2_BRK_PREFIX) begin
        brk_d = 1'b1;
      end else begin
        w_push = 1'b1;
        ext_d  = 1'b0;
        brk_d  = 1'b0;
        if (!ext_q && (shift_q == KEY_CODE)) key_held_d = ~brk_q;
      end
    end
  end

  // Prefix flags and held-key level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      key_held_q <= 1'b0;
    end else begin
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      key_held_q <= key_held_d;
    end
  end

  assign key_held = key_held_q;
`else
  assign w_push   = byte_vld_q;
  assign w_evt    = {2'b00, shift_q};
  assign key_held = 1'b0;
`endif

  logic w_unused_cfg;
  assign w_unused_cfg = ^{KEY_CODE, 32'(CLK_HZ)};

  // ---------------------------------------------------------------- FIFO
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_ovf;

  assign w_pop = rd_if.rd_en & ~w_empty;
  assign w_ovf = w_push & w_full & ~w_pop;

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_EVT_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (w_push),
    .push_data_i (w_evt),
    .pop_i       (rd_if.rd_en),
    .pop_data_o  (rd_if.rd_data),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (rd_if.fifo_count)
  );

  assign rd_if.rd_valid = ~w_empty;

  // -------------------------------------------------------------- errors
  logic parity_err_q;
  logic frame_err_q;
  logic overflow_err_q;

  // Sticky flags; a new set beats a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      parity_err_q   <= perr_evt_q | (parity_err_q   & ~err_clr);
      frame_err_q    <= ferr_evt_q | (frame_err_q    & ~err_clr);
      overflow_err_q <= w_ovf      | (overflow_err_q & ~err_clr);
    end
  end

  assign parity_err   = parity_err_q;
  assign frame_err    = frame_err_q;
  assign overflow_err = overflow_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_kbd_rx
//  Purpose  : Self-checking bench for ps2_kbd_rx: directed scenarios plus
//             randomized frames against a behavioural event model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_kbd_rx;

  localparam int         DEPTH = 8;
  localparam int         FL    = 8;
  localparam int         TO    = 2000;
  localparam logic [7:0] KEY   = 8'h29;
  localparam int         HALF  = 30;

  logic clk = 1'b0;
  logic rst_n;
  logic ps2c;
  logic ps2d;
  logic err_clr;
  logic key_held, parity_err, frame_err, overflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_kbd_rx_if #(.FIFO_DEPTH(DEPTH)) kbd_if ();

  ps2_kbd_rx #(
    .CLK_HZ         (100_000_000),
    .FIFO_DEPTH     (DEPTH),
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO),
    .KEY_CODE       (KEY)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .ps2_clk      (ps2c),
    .ps2_dat      (ps2d),
    .err_clr      (err_clr),
    .rd_if        (kbd_if),
    .key_held     (key_held),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  logic [9:0] exp_q[$];
  bit m_ext, m_brk, m_key, m_perr, m_ferr, m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_emit(input logic [9:0] ev);
    if (exp_q.size() < DEPTH) exp_q.push_back(ev);
    else m_ovf = 1'b1;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    if (par_bad) begin
      m_perr = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
    end else if (stop_bad) begin
      m_ferr = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
    end else begin
`ifdef PS2_KBD_EXT_DECODE_EN
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        if (!m_ext && b == KEY) m_key = !m_brk;
        model_emit({m_brk, m_ext, b});
        m_ext = 1'b0; m_brk = 1'b0;
      end
`else
      model_emit({2'b00, b});
`endif
    end
  endfunction

  // ---------------------------------------------------------------- tasks
  task automatic check_state(input string tag);
    check_eq({tag, ":count"}, 32'(kbd_if.fifo_count), 32'(exp_q.size()));
    check_eq({tag, ":valid"}, 32'(kbd_if.rd_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check_eq({tag, ":head"}, 32'(kbd_if.rd_data), 32'(exp_q[0]));
    check_eq({tag, ":perr"}, 32'(parity_err), 32'(m_perr));
    check_eq({tag, ":ferr"}, 32'(frame_err), 32'(m_ferr));
    check_eq({tag, ":ovf"}, 32'(overflow_err), 32'(m_ovf));
    check_eq({tag, ":held"}, 32'(key_held), 32'(m_key));
  endtask

  // One PS/2 bit: data set while clock high, then a low and a high half period
  task automatic send_bit(input logic v);
    @(negedge clk) ps2d = v;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad,
                            input bit check_lat);
    logic [10:0] bits;
    bits = {~stop_bad, (~^b) ^ par_bad, b, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(bits[i]);
    @(negedge clk) ps2d = bits[10];
    repeat (HALF) @(negedge clk);
    ps2c = 1'b0;
    if (check_lat) begin
      repeat (FL + 3) @(posedge clk);
      #1;
      check_eq("lat_valid_before", 32'(kbd_if.rd_valid), 32'd0);
      check_eq("lat_held_before", 32'(key_held), 32'd0);
      @(posedge clk);
      #1;
      check_eq("lat_valid_at", 32'(kbd_if.rd_valid), 32'd1);
`ifdef PS2_KBD_EXT_DECODE_EN
      check_eq("lat_held_at", 32'(key_held), 32'd1);
`endif
      repeat (HALF - FL - 5) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2c = 1'b1;
    ps2d = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    model_frame(b, par_bad, stop_bad);
  endtask

  task automatic pop_some(input int n);
    for (int k = 0; k < n && exp_q.size() > 0; k++) begin
      @(negedge clk);
      check_eq("pop_valid", 32'(kbd_if.rd_valid), 32'd1);
      check_eq("pop_data", 32'(kbd_if.rd_data), 32'(exp_q[0]));
      kbd_if.rd_en = 1'b1;
      @(negedge clk);
      kbd_if.rd_en = 1'b0;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic drain(input string tag);
    pop_some(DEPTH + 1);
    @(negedge clk);
    check_eq({tag, ":drained_valid"}, 32'(kbd_if.rd_valid), 32'd0);
    check_eq({tag, ":drained_count"}, 32'(kbd_if.fifo_count), 32'd0);
  endtask

  task automatic clear_errors();
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    logic [7:0] b;
    int         r;
    rst_n = 1'b0; ps2c = 1'b1; ps2d = 1'b1; err_clr = 1'b0; kbd_if.rd_en = 1'b0;
    repeat (5) @(negedge clk);
    check_state("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single make code with exact latency
    send_frame(KEY, 0, 0, 1);
    check_state("make_key");
    drain("make_key");

    // Break and extended sequences
    send_frame(8'hF0, 0, 0, 0);
    send_frame(KEY, 0, 0, 0);
    check_state("break_key");
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'h75, 0, 0, 0);
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h75, 0, 0, 0);
    check_state("ext_seq");
    drain("ext_seq");

    // Parity error, clear, then good byte
    send_frame(8'h1C, 1, 0, 0);
    check_state("parity_bad");
    clear_errors();
    check_state("parity_clr");
    send_frame(8'h1C, 0, 0, 0);
    check_state("after_parity");
    drain("after_parity");

    // Overflow with no reads
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(8'h10 + i), 0, 0, 0);
    check_state("overflow");
    drain("overflow");
    @(negedge clk) kbd_if.rd_en = 1'b1;
    @(negedge clk) kbd_if.rd_en = 1'b0;
    check_eq("pop_empty_count", 32'(kbd_if.fifo_count), 32'd0);
    clear_errors();

    // Truncated frame: start plus 3 data bits, then the clock stops
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk) ps2d = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b1;
    repeat (TO - 20 - HALF) @(negedge clk);
    check_eq("timeout_early", 32'(frame_err), 32'd0);
    repeat (80) @(negedge clk);
    m_ferr = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
    check_state("timeout");
    send_frame(KEY, 0, 0, 0);
    check_state("after_timeout");
    drain("after_timeout");
    clear_errors();

    // Short glitch on idle clock must be ignored
    @(negedge clk) ps2c = 1'b0;
    repeat (3) @(negedge clk);
    ps2c = 1'b1;
    repeat (40) @(negedge clk);
    check_state("glitch");
    send_frame(8'h5A, 0, 0, 0);
    check_state("after_glitch");
    drain("after_glitch");

    // Randomized frames
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2)       b = 8'hE0;
      else if (r == 2) b = 8'hF0;
      else if (r == 3) b = KEY;
      else             b = 8'($urandom_range(0, 255));
      send_frame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0), 0);
      check_state("rand");
      if ($urandom_range(0, 3) == 0) pop_some($urandom_range(1, DEPTH));
      if ($urandom_range(0, 5) == 0) clear_errors();
    end
    drain("rand_end");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #5ms;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

Parametrised PS/2 keyboard receiver for the CPU top level. It synchronises and de-glitches the open-drain PS/2 clock and data lines, deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop), and decodes E0/F0 prefixes into key events. Events are queued in a FIFO that the CPU reads. A configurable hold-key output generalises the single space-key LED path.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency; documentation only.
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, ≥2.
- `FILTER_LEN`, 8: consecutive equal samples required before the filtered PS/2 clock changes.
- `TIMEOUT_CYCLES`, 100_000: maximum clk cycles between PS/2 clock falling edges inside a frame (2 ms at 50 MHz).
- `KEY_CODE`, 8'h29: non-extended scancode tracked by `key_held`.
- `clk`  in  1: system clock; all logic on rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `ps2_clk`  in  1: raw PS/2 clock; asynchronous.
- `ps2_dat`  in  1: raw PS/2 data; asynchronous.
- `rd_en`  in  1: pop the head event when `rd_valid` is high.
- `err_clr`  in  1: clears all sticky error flags.
- `rd_valid`  out  1: FIFO not empty.
- `rd_data`  out  10: head event {brk, ext, code[7:0]}; first-word fall-through.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1: number of occupied entries.
- `key_held`  out  1: level, high while `KEY_CODE` is pressed.
- `parity_err`, `frame_err`, `overflow_err`  out  1 each: sticky error flags.

## Operation
- Synchronise both PS/2 lines with 2 flip-flops. Filter the clock: the filtered clock takes the new level only after FILTER_LEN identical synchronised samples.
- Sample data on each filtered-clock falling edge.
- Frame FSM states: IDLE → DATA (8 bits, LSB first) → PARITY → STOP → IDLE.
  - IDLE: a sampled 1 as the start bit is ignored and the FSM stays in IDLE.
  - Parity must be odd over data plus parity bit. On failure: set `parity_err`, discard the byte.
  - Stop bit must be 1. On failure: set `frame_err`, discard the byte.
  - Timeout: outside IDLE, if no falling edge arrives for TIMEOUT_CYCLES, set `frame_err` and return to IDLE. Partial bits are dropped.
- Decoder, applied to each good byte:
  - 8'hE0: set `ext` flag.
  - 8'hF0: set `brk` flag.
  - Any other byte: emit {brk, ext, byte} and clear both flags.
  - A framing or parity error clears both flags.
- FIFO push when an event is emitted:
  - Not full: push the event.
  - Full with no pop that cycle: drop the new event and set `overflow_err`. Stored contents are unchanged.
  - Full with a pop that cycle: push and pop both succeed; `fifo_count` is unchanged.
  - `rd_en` while empty: ignored.
- `key_held`:
  - Set on event {0, 0, KEY_CODE}; cleared on event {1, 0, KEY_CODE}.
  - Updated in the emit cycle, even when the event is dropped on overflow.
- `err_clr` clears all sticky flags. If a flag sets in the same cycle as `err_clr`, the set wins.

## Timing
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, prefix flags cleared, filter state high (bus idle). Reset mid-frame discards everything.
- Latency: `rd_valid` and `key_held` update exactly FILTER_LEN+4 clk cycles after the raw `ps2_clk` falling edge of the stop bit (2 sync + FILTER_LEN filter + 1 edge/sample + 1 decode/push).
- `rd_data` is valid combinationally from FIFO head storage while `rd_valid` is high. After a pop, the next entry is visible the following cycle.
- Pointers wrap modulo FIFO_DEPTH. `fifo_count` ranges 0..FIFO_DEPTH.

## Configuration
- `PS2_KBD_EXT_DECODE_EN` defined: E0/F0 prefix decoding and `key_held` behave as described above.
- Not defined:
  - Every good byte, including E0 and F0, is pushed raw as {2'b00, byte}.
  - No prefix flags exist.
  - `key_held` is tied to 0.

## Structure
- Package `ps2_pkg` holds:
  - frame FSM state enum;
  - constants `PS2_EXT_PREFIX` = 8'hE0 and `PS2_BRK_PREFIX` = 8'hF0;
  - event width constant (10) and event field bit positions.
- One sub-module, `ps2_event_fifo`: synchronous FWFT FIFO parametrised by DEPTH and WIDTH, with push/pop/full/empty/count.
- Synchroniser, filter, FSM and decoder stay in the top module.

## Test plan
- Send 0x29 with KEY_CODE=0x29 → one event 10'h029; `key_held` rises exactly FILTER_LEN+4 cycles after the stop-bit falling edge.
- Send F0, 29 → single event 10'h229; `key_held` falls. Send E0, 75 → event 10'h175. Send E0, F0, 75 → event 10'h375.
- Send 0x1C with inverted parity → no event, `parity_err`=1. Pulse `err_clr` → `parity_err`=0. Following good 0x1C → event 10'h01C.
- Send FIFO_DEPTH+1 bytes 0x10..0x18 with no reads → `fifo_count`=8, `overflow_err`=1, pops return 0x010..0x017 in order, then `rd_valid`=0.
- Send start bit plus 3 data bits, then idle the clock → `frame_err` set TIMEOUT_CYCLES after the last edge. Following 0x29 is received correctly.
- Inject a 3-cycle low glitch on idle `ps2_clk` (FILTER_LEN=8) → FSM stays in IDLE, no event, no error flag.
